booth_mult: RTL and testbench
=============================

BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` in, 1 bit, rising-edge clock; `reset` in, 1 bit, sampled only on the rising edge of `clk`.
REQ-002 The block SHALL have these data ports:
- `ctrl_mult` in, 1: start pulse; operands are sampled on the same edge.
- `data_operandA` in, 32: multiplicand, two's complement.
- `data_operandB` in, 32: multiplier, two's complement.
REQ-003 The block SHALL have these step-counter ports:
- `cnt` in, 5: current step count from the external 5-bit multdiv step counter.
- `cnt_end` in, 1: high when `cnt` == 31.
- `cnt_reset` out, 1: drives the counter's reset input.
REQ-004 The block SHALL have these result ports:
- `data_result` out, 32: low 32 bits of the product.
- `data_exception` out, 1: overflow flag.
- `data_resultRDY` out, 1: one-cycle result-valid pulse.
REQ-005 The block SHALL rely on this counter contract: when `cnt_reset` is high at an edge, `cnt` is 0 after that edge; otherwise `cnt` increments each edge and saturates at 31 with `cnt_end`=1.

Function
REQ-006 The FSM SHALL have four states: IDLE, CLR, RUN and DONE, encoded in 2 bits.
REQ-007 IDLE: at an edge with `ctrl_mult`=1, the block SHALL latch M=`data_operandA`, load product register P={32'b0, `data_operandB`, 1'b0} (65 bits), and go to CLR.
REQ-008 CLR SHALL drive `cnt_reset`=1 combinationally for exactly one cycle and go to RUN at the next edge; `cnt_reset` SHALL be 0 in every other state except as required by REQ-016.
REQ-009 RUN: at each edge the block SHALL perform one radix-2 Booth step on P.
- P[1:0]=01: P[64:33] += M.
- P[1:0]=10: P[64:33] -= M.
- P[1:0]=00 or 11: no add.
- Then P SHALL be arithmetically shifted right by 1.
- Arithmetic SHALL be 32-bit modulo; the carry is discarded.
REQ-010 RUN SHALL go to DONE at the edge where `cnt_end`=1, after performing that step; RUN therefore performs exactly 32 steps (`cnt` 0..31).
REQ-011 DONE SHALL assert `data_resultRDY`=1 for exactly one cycle and go to IDLE at the next edge.
REQ-012 Latency: with `ctrl_mult` sampled at edge E0, `data_resultRDY` SHALL be high during the cycle following edge E0+33.
REQ-013 `data_result` SHALL equal P[32:1], be registered, and be updated at the edge entering DONE.
REQ-014 `data_result` SHALL hold its value until the next entry to DONE or a reset.
REQ-015 Operands SHALL be ignored except at the start edge; input changes during RUN SHALL have no effect.
REQ-016 `ctrl_mult`=1 in CLR, RUN or DONE SHALL abort the current operation, re-latch the operands per REQ-007, and go to CLR; no `data_resultRDY` pulse SHALL be produced for the aborted operation.
REQ-017 Operand corner cases SHALL be handled by plain Booth arithmetic with no special cases: M=0, B=0, and M=0x80000000 (where -M wraps).

Reset
REQ-018 `reset`=1 at an edge SHALL force state to IDLE and clear `data_result`=0, `data_exception`=0, P=0 and M=0; `data_resultRDY` and `cnt_reset` SHALL be 0 in the following cycle.
REQ-019 Reset SHALL take priority over `ctrl_mult` at the same edge.
REQ-020 Reset during CLR, RUN or DONE SHALL discard the operation with no `data_resultRDY` pulse.

Configuration
REQ-021 The macro `MULT_OVF_EN` SHALL control overflow detection.
- Defined: at the edge entering DONE, `data_exception` SHALL be loaded with 1 if P[64:33] differs from the 32-bit replication of P[32], else 0; it SHALL hold until the next entry to DONE or a reset.
- Not defined: `data_exception` SHALL be constant 0, and the comparison logic SHALL be absent.

Verification
REQ-022 The bench SHALL cover these directed scenarios, with the counter contract of REQ-005 modelled or instantiated:
- A=3, B=5, start at E0 -> `data_resultRDY` high after E0+33, `data_result`=0x0000000F, `data_exception`=0.
- A=-7 (0xFFFFFFF9), B=6 -> `data_result`=0xFFFFFFD6, `data_exception`=0.
- A=0x00010000, B=0x00010000 -> `data_result`=0x00000000; `data_exception`=1 with `MULT_OVF_EN` defined, 0 without.
- A=0x80000000, B=0xFFFFFFFF -> `data_result`=0x80000000; `data_exception`=1 with `MULT_OVF_EN` defined.
- Start 2*2, assert `reset` at the edge where `cnt`=10 -> no `data_resultRDY` pulse; `data_result`=0; the next start 4*4 yields 16 after 34 cycles.
- Start 2*2, re-pulse `ctrl_mult` with 9*9 at `cnt`=20 -> exactly one `data_resultRDY` pulse, 33 edges after the second start, `data_result`=81.

Source files
------------

// File: rtl/booth_mult_if.sv
// ---------------------------------------------------------------------------
// booth_mult_if
// Request/result bundle between a multiply requester and booth_mult.
//   ctrl_mult       : start pulse; operands sampled on the same edge
//   data_operandA   : 32-bit two's-complement multiplicand
//   data_operandB   : 32-bit two's-complement multiplier
//   data_result     : low 32 bits of the product (registered)
//   data_exception  : overflow flag (registered, or constant 0)
//   data_resultRDY  : one-cycle result-valid pulse
// Modports: master = requester, slave = multiplier.
// ---------------------------------------------------------------------------
interface booth_mult_if;
  logic        ctrl_mult;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output ctrl_mult, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_mult, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/booth_mult.sv
// ---------------------------------------------------------------------------
// booth_mult
// Sequential radix-2 Booth multiplier, 32x32 signed, one Booth step per clock
// paced by an external 5-bit step counter.
//
// Ports
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset
//   cnt        : current step count from the external counter
//   cnt_end    : high when cnt == 31
//   cnt_reset  : clears the external counter (high while in CLR)
//   bus        : booth_mult_if.slave (start, operands, result, flags)
//
// Optional build macro
//   MULT_OVF_EN : when defined, data_exception flags a product that does not
//                 fit in 32 signed bits; when undefined it is tied to 0 and
//                 no comparison logic exists.
//
// Timing: start sampled at edge E0 -> CLR -> 32 RUN steps -> DONE, with
// data_resultRDY high during the cycle after edge E0+33.
// ---------------------------------------------------------------------------
module booth_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  cnt,
  input  logic        cnt_end,
  output logic        cnt_reset,
  booth_mult_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         r_state;
  logic signed [31:0] r_m;
  logic [64:0]        r_prod;
  logic [31:0]        r_result;
  logic [64:0]        w_prod_next;
  logic               w_last_step;

  // One Booth step: conditional add/sub of M into the upper half, then an
  // arithmetic shift right of the whole product register. The add is done
  // one bit wider so the bit shifted into the top is the true sign of the
  // partial product even when the 32-bit sum wraps (e.g. M = 0x80000000);
  // the low half is identical to plain modulo arithmetic, and the upper half
  // stays the exact high word of the product.
  function automatic logic [64:0] booth_step(input logic [64:0]        p,
                                             input logic signed [31:0] m);
    logic signed [32:0] acc;
    logic signed [32:0] m_ext;
    acc   = {p[64], p[64:33]};
    m_ext = {m[31], m};
    case (p[1:0])
      2'b01:   acc = acc + m_ext;
      2'b10:   acc = acc - m_ext;
      default: acc = acc;
    endcase
    return {acc, p[32:1]};
  endfunction

  assign w_prod_next = booth_step(r_prod, r_m);

  // The end flag is qualified with the count itself so a spurious cnt_end
  // alone cannot terminate the multiply early.
  assign w_last_step = cnt_end & (&cnt);

  assign cnt_reset          = (r_state == S_CLR);
  assign bus.data_resultRDY = (r_state == S_DONE);
  assign bus.data_result    = r_result;

  // Control and datapath: a start pulse in any state (re)loads the operands,
  // which also aborts any operation in flight without a ready pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_m      <= '0;
      r_prod   <= '0;
      r_result <= '0;
    end else if (bus.ctrl_mult) begin
      r_state  <= S_CLR;
      r_m      <= bus.data_operandA;
      r_prod   <= {32'b0, bus.data_operandB, 1'b0};
    end else begin
      case (r_state)
        S_CLR:   r_state <= S_RUN;
        S_RUN: begin
          r_prod <= w_prod_next;
          if (w_last_step) begin
            r_state  <= S_DONE;
            r_result <= w_prod_next[32:1];
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MULT_OVF_EN
  logic r_exc;

  // The product overflows 32 bits when the high word is not merely the sign
  // extension of bit 31 of the low word.
  function automatic logic ovf_check(input logic [64:0] p);
    return (p[64:33] != {32{p[32]}});
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc <= 1'b0;
    end else if (!bus.ctrl_mult && (r_state == S_RUN) && w_last_step) begin
      r_exc <= ovf_check(w_prod_next);
    end
  end

  assign bus.data_exception = r_exc;
`else
  assign bus.data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult.sv
// ---------------------------------------------------------------------------
// tb_booth_mult
// Self-checking bench for booth_mult. Models the external 5-bit step counter,
// and checks results against a signed 64-bit arithmetic reference.
// Compile with +define+MULT_OVF_EN to exercise the overflow flag.
// ---------------------------------------------------------------------------
module tb_booth_mult;

`ifdef MULT_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] cnt = 5'd31;
  logic       cnt_end;
  logic       cnt_reset;
  int         n_tests = 0;
  int         n_fail  = 0;

  booth_mult_if bus();

  booth_mult dut (
    .clk       (clk),
    .reset     (reset),
    .cnt       (cnt),
    .cnt_end   (cnt_end),
    .cnt_reset (cnt_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // External step counter: cleared by cnt_reset, otherwise counts and
  // saturates at 31.
  always @(posedge clk) begin
    if (cnt_reset)          cnt <= 5'd0;
    else if (cnt != 5'd31)  cnt <= cnt + 5'd1;
  end
  assign cnt_end = (cnt == 5'd31);

  // Reference: full signed product; result is the low word, overflow when
  // the product does not fit in 32 signed bits.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic ovf;
    p   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    ovf = OVF && (p[63:32] != {32{p[31]}});
    return {ovf, p[31:0]};
  endfunction

  // Drive a start pulse; returns at the falling edge just after start edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ctrl_mult     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clk);
    bus.ctrl_mult     = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Returns number of edges after E0 at which ready was first seen (0 = timeout).
  // Operands are scrambled every cycle to show they are ignored mid-run.
  task automatic wait_rdy(output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.data_resultRDY === 1'b1) begin
        n = i;
        break;
      end
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
    end
  endtask

  task automatic wait_cnt(input logic [4:0] target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cnt == target) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int pulses;
    reset = 1'b1;
    bus.ctrl_mult     = 1'b1;
    bus.data_operandA = 32'd5;
    bus.data_operandB = 32'd7;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.ctrl_mult = 1'b0;
    n_tests++;
    if (bus.data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", bus.data_resultRDY); end
    n_tests++;
    if (cnt_reset !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_reset: got %b expected 0", cnt_reset); end
    n_tests++;
    if (bus.data_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.data_result); end
    n_tests++;
    if (bus.data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc: got %b expected 0", bus.data_exception); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.data_resultRDY === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL reset_priority_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_directed;
    logic [31:0] ta [4] = '{32'd3, 32'hFFFF_FFF9, 32'h0001_0000, 32'h8000_0000};
    logic [31:0] tb [4] = '{32'd5, 32'd6,         32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] er [4] = '{32'h0000_000F, 32'hFFFF_FFD6, 32'h0000_0000, 32'h8000_0000};
    logic        ee [4] = '{1'b0, 1'b0, OVF, OVF};
    int n;
    for (int i = 0; i < 4; i++) begin
      start_op(ta[i], tb[i]);
      n_tests++;
      if (cnt_reset !== 1'b1) begin n_fail++; $display("FAIL dir%0d_cnt_reset: got %b expected 1", i, cnt_reset); end
      wait_rdy(n);
      n_tests++;
      if (n != 33) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 33", i, n); end
      n_tests++;
      if (bus.data_result !== er[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h expected %h", i, bus.data_result, er[i]); end
      n_tests++;
      if (bus.data_exception !== ee[i]) begin n_fail++; $display("FAIL dir%0d_exc: got %b expected %b", i, bus.data_exception, ee[i]); end
      @(negedge clk);
      n_tests++;
      if (bus.data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL dir%0d_rdy_width: got %b expected 0", i, bus.data_resultRDY); end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [32:0] exp;
    int n;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case (i)
        0: a = 32'd0;
        1: b = 32'd0;
        2: a = 32'h8000_0000;
        3: begin a = 32'h8000_0000; b = 32'h8000_0000; end
        4: begin a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; end
        5: begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        6: b = 32'h8000_0000;
        7: begin a = $urandom_range(0, 65535); b = $urandom_range(0, 65535); end
        default: ;
      endcase
      exp = model(a, b);
      start_op(a, b);
      wait_rdy(n);
      n_tests++;
      if (n != 33) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected 33", i, n); end
      n_tests++;
      if (bus.data_result !== exp[31:0]) begin n_fail++; $display("FAIL rnd%0d_result a=%h b=%h: got %h expected %h", i, a, b, bus.data_result, exp[31:0]); end
      n_tests++;
      if (bus.data_exception !== exp[32]) begin n_fail++; $display("FAIL rnd%0d_exc a=%h b=%h: got %b expected %b", i, a, b, bus.data_exception, exp[32]); end
      repeat (3) begin
        @(negedge clk);
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
      end
      n_tests++;
      if (bus.data_result !== exp[31:0]) begin n_fail++; $display("FAIL rnd%0d_hold: got %h expected %h", i, bus.data_result, exp[31:0]); end
    end
  endtask

  task automatic test_reset_abort;
    bit found;
    int pulses, n;
    start_op(32'd2, 32'd2);
    wait_cnt(5'd10, found);
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rst_abort_cnt10: got %b expected 1", found); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (bus.data_result !== 32'd0) begin n_fail++; $display("FAIL rst_abort_result: got %h expected 00000000", bus.data_result); end
    n_tests++;
    if (cnt_reset !== 1'b0) begin n_fail++; $display("FAIL rst_abort_cnt_reset: got %b expected 0", cnt_reset); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.data_resultRDY === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin n_fail++; $display("FAIL rst_abort_pulses: got %0d expected 0", pulses); end
    start_op(32'd4, 32'd4);
    wait_rdy(n);
    n_tests++;
    if (n != 33) begin n_fail++; $display("FAIL rst_abort_next_latency: got %0d expected 33", n); end
    n_tests++;
    if (bus.data_result !== 32'd16) begin n_fail++; $display("FAIL rst_abort_next_result: got %h expected 00000010", bus.data_result); end
  endtask

  task automatic test_restart;
    bit found;
    int pulses, first;
    start_op(32'd2, 32'd2);
    wait_cnt(5'd20, found);
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL restart_cnt20: got %b expected 1", found); end
    bus.ctrl_mult     = 1'b1;
    bus.data_operandA = 32'd9;
    bus.data_operandB = 32'd9;
    @(negedge clk);
    bus.ctrl_mult = 1'b0;
    pulses = 0;
    first  = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      if (bus.data_resultRDY === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = i;
          n_tests++;
          if (bus.data_result !== 32'd81) begin n_fail++; $display("FAIL restart_result: got %h expected 00000051", bus.data_result); end
        end
      end
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL restart_pulses: got %0d expected 1", pulses); end
    n_tests++;
    if (first != 33) begin n_fail++; $display("FAIL restart_latency: got %0d expected 33", first); end
  endtask

  initial begin
    bus.ctrl_mult     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
